// File: rtl/mmio_button_input_if.sv
// Core-facing MMIO port of the button input block: clear strobes toward the
// block, conditioned button state back to the core.
interface mmio_button_input_if #(
  parameter int NUM_INPUTS = 4
) ();
  logic                  clearWrite;
  logic [NUM_INPUTS-1:0] clearMask;
  logic                  countClear;
  logic [NUM_INPUTS-1:0] debounced;
  logic [NUM_INPUTS-1:0] pressPending;
  logic                  anyPending;
  logic [7:0]            pressCount;

  // Core side
  modport master (
    output clearWrite, clearMask, countClear,
    input  debounced, pressPending, anyPending, pressCount
  );

  // Button block side
  modport slave (
    input  clearWrite, clearMask, countClear,
    output debounced, pressPending, anyPending, pressCount
  );
endinterface

// File: rtl/mmio_button_input.sv
// Push-button input path: two-flop synchronizer, per-channel debounce, press
// detection with sticky write-1-to-clear flags and a saturating press counter.
module mmio_button_input #(
  parameter int NUM_INPUTS      = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit INVERT_INPUT    = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] rawInput,
  mmio_button_input_if.slave    mmio
);
  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int ROSE_W = $clog2(NUM_INPUTS + 1);
  localparam int SUM_W  = (ROSE_W > 8) ? ROSE_W + 1 : 9;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_INPUTS-1:0] sync1_reg;
  logic [NUM_INPUTS-1:0] sync2_reg;
  logic [NUM_INPUTS-1:0] debounced_reg;
  logic [NUM_INPUTS-1:0] debounced_next;
  logic [NUM_INPUTS-1:0] rise;
  logic [NUM_INPUTS-1:0] pending_reg;
  logic [NUM_INPUTS-1:0] pending_next;
  logic                  any_pending_reg;
  logic [7:0]            press_count_reg;
  logic [7:0]            press_count_next;
  logic [ROSE_W-1:0]     rise_total;
  logic [SUM_W-1:0]      count_sum;

  // No logic between the stages so the second flop can resolve metastability.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= rawInput ^ {NUM_INPUTS{INVERT_INPUT}};
      sync2_reg <= sync1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_debounce
      logic [CNT_W-1:0] count_reg;
      logic [CNT_W-1:0] count_next;
      logic             deb_bit_next;

      // Accept a new level only after it has differed for DEBOUNCE_CYCLES edges in a row.
      always_comb begin
        count_next   = count_reg;
        deb_bit_next = debounced_reg[gi];
        if (sync2_reg[gi] == debounced_reg[gi]) begin
          count_next = '0;
        end else if (count_reg == LAST_COUNT) begin
          deb_bit_next = sync2_reg[gi];
          count_next   = '0;
        end else begin
          count_next = count_reg + 1'b1;
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          count_reg <= '0;
        end else begin
          count_reg <= count_next;
        end
      end

      assign debounced_next[gi] = deb_bit_next;
    end
  endgenerate

  assign rise = debounced_next & ~debounced_reg;

  always_comb begin
    rise_total = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      rise_total = rise_total + ROSE_W'(rise[i]);
    end
  end

  // Set is OR'd in after the clear so a coincident press keeps the flag.
  always_comb begin
    pending_next = pending_reg & ~(mmio.clearWrite ? mmio.clearMask : '0);
    pending_next = pending_next | rise;
  end

  // countClear only zeroes the base; rises on the same edge still count.
  always_comb begin
    count_sum = (mmio.countClear ? '0 : SUM_W'(press_count_reg)) + SUM_W'(rise_total);
    if (count_sum > SUM_W'(255)) begin
      press_count_next = 8'hff;
    end else begin
      press_count_next = count_sum[7:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      debounced_reg   <= '0;
      pending_reg     <= '0;
      any_pending_reg <= 1'b0;
      press_count_reg <= '0;
    end else begin
      debounced_reg   <= debounced_next;
      pending_reg     <= pending_next;
      any_pending_reg <= |pending_next;
      press_count_reg <= press_count_next;
    end
  end

  assign mmio.debounced    = debounced_reg;
  assign mmio.pressPending = pending_reg;
  assign mmio.anyPending   = any_pending_reg;
  assign mmio.pressCount   = press_count_reg;
endmodule

// File: tb/tb_mmio_button_input.sv
// Bench for mmio_button_input: a normal and an inverted-input instance run
// side by side against a streak-counting behavioural model of the buttons.
module tb_mmio_button_input;
  localparam int N = 4;
  localparam int D = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] raw   = '0;
  logic [N-1:0] raw_inv;
  logic         cw    = 1'b0;
  logic [N-1:0] cm    = '0;
  logic         cc    = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model state
  logic [N-1:0] m_h1, m_h2, m_deb, m_pend;
  int           m_streak [N];
  int           m_cnt;

  always #5 clock = ~clock;

  assign raw_inv = ~raw;

  mmio_button_input_if #(.NUM_INPUTS(N)) mmio_a ();
  mmio_button_input_if #(.NUM_INPUTS(N)) mmio_b ();

  assign mmio_a.clearWrite = cw;
  assign mmio_a.clearMask  = cm;
  assign mmio_a.countClear = cc;
  assign mmio_b.clearWrite = cw;
  assign mmio_b.clearMask  = cm;
  assign mmio_b.countClear = cc;

  mmio_button_input #(.NUM_INPUTS(N), .DEBOUNCE_CYCLES(D), .INVERT_INPUT(1'b0)) dut_a (
    .clock    (clock),
    .reset    (reset),
    .rawInput (raw),
    .mmio     (mmio_a)
  );

  mmio_button_input #(.NUM_INPUTS(N), .DEBOUNCE_CYCLES(D), .INVERT_INPUT(1'b1)) dut_b (
    .clock    (clock),
    .reset    (reset),
    .rawInput (raw_inv),
    .mmio     (mmio_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A level is accepted once the synchronized pin (two edges old) has differed
  // from the accepted level for D consecutive edges.
  task automatic model_step();
    logic [N-1:0] rise_vec;
    int rises;
    if (reset) begin
      m_h1 = '0; m_h2 = '0; m_deb = '0; m_pend = '0; m_cnt = 0;
      for (int i = 0; i < N; i++) m_streak[i] = 0;
    end else begin
      rise_vec = '0;
      rises = 0;
      for (int i = 0; i < N; i++) begin
        if (m_h2[i] != m_deb[i]) begin
          m_streak[i]++;
          if (m_streak[i] == D) begin
            m_deb[i] = m_h2[i];
            m_streak[i] = 0;
            if (m_deb[i]) begin
              rise_vec[i] = 1'b1;
              rises++;
            end
          end
        end else begin
          m_streak[i] = 0;
        end
      end
      m_pend = (m_pend & ~(cw ? cm : '0)) | rise_vec;
      m_cnt  = (cc ? 0 : m_cnt) + rises;
      if (m_cnt > 255) m_cnt = 255;
      m_h2 = m_h1;
      m_h1 = raw;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check("a_debounced", 32'(mmio_a.debounced),    32'(m_deb));
    check("a_pending",   32'(mmio_a.pressPending), 32'(m_pend));
    check("a_any",       32'(mmio_a.anyPending),   32'(|m_pend));
    check("a_count",     32'(mmio_a.pressCount),   32'(m_cnt));
    check("b_debounced", 32'(mmio_b.debounced),    32'(m_deb));
    check("b_pending",   32'(mmio_b.pressPending), 32'(m_pend));
    check("b_any",       32'(mmio_b.anyPending),   32'(|m_pend));
    check("b_count",     32'(mmio_b.pressCount),   32'(m_cnt));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    // Reset state
    ticks(2);
    check("reset_count", 32'(mmio_a.pressCount), 32'd0);
    check("reset_inv_debounced", 32'(mmio_b.debounced), 32'd0);
    reset = 1'b0;
    ticks(3);

    // Clean step on channel 0: visible on the 6th edge, not before
    raw[0] = 1'b1;
    ticks(5);
    check("step_not_early", 32'(mmio_a.debounced), 32'd0);
    tick();
    check("step_debounced", 32'(mmio_a.debounced), 32'h1);
    check("step_pending",   32'(mmio_a.pressPending), 32'h1);
    check("step_any",       32'(mmio_a.anyPending), 32'h1);
    check("step_count",     32'(mmio_a.pressCount), 32'd1);

    // Short glitch rejected, long pulse accepted then released
    raw[1] = 1'b1; ticks(3);
    raw[1] = 1'b0; ticks(10);
    check("glitch_rejected", 32'(mmio_a.debounced), 32'h1);
    raw[1] = 1'b1; ticks(5);
    raw[1] = 1'b0; ticks(12);
    check("pulse_count",   32'(mmio_a.pressCount), 32'd2);
    check("pulse_pending", 32'(mmio_a.pressPending), 32'h3);
    check("pulse_release", 32'(mmio_a.debounced), 32'h1);

    // Write-1-to-clear, then a clear colliding with a new press
    cw = 1'b1; cm = 4'b0001; tick();
    cw = 1'b0; cm = 4'b1111; tick();
    check("clear_ch0", 32'(mmio_a.pressPending), 32'h2);
    raw[1] = 1'b1; ticks(5);
    cw = 1'b1; cm = 4'b0010; tick();
    cw = 1'b0; cm = '0;
    check("set_beats_clear", 32'(mmio_a.pressPending), 32'h2);
    check("collide_count",   32'(mmio_a.pressCount), 32'd3);
    raw = '0; ticks(8);

    // Saturation: 64 four-channel presses
    for (int p = 0; p < 64; p++) begin
      raw = 4'hf; ticks(7);
      raw = 4'h0; ticks(7);
    end
    check("saturated", 32'(mmio_a.pressCount), 32'd255);
    raw = 4'hf; ticks(7);
    raw = 4'h0; ticks(7);
    check("stays_saturated", 32'(mmio_a.pressCount), 32'd255);
    cc = 1'b1; tick();
    cc = 1'b0;
    check("count_cleared", 32'(mmio_a.pressCount), 32'd0);

    // Reset mid-operation with channel 3 held
    for (int p = 0; p < 7; p++) begin
      raw = 4'h1; ticks(7);
      raw = 4'h0; ticks(7);
    end
    check("count_seven", 32'(mmio_a.pressCount), 32'd7);
    raw[3] = 1'b1; ticks(3);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("in_reset_count", 32'(mmio_a.pressCount), 32'd0);
      check("in_reset_debounced", 32'(mmio_a.debounced), 32'd0);
    end
    reset = 1'b0;
    ticks(5);
    check("post_reset_early", 32'(mmio_a.debounced), 32'd0);
    tick();
    check("post_reset_debounced", 32'(mmio_a.debounced), 32'h8);
    check("post_reset_count",     32'(mmio_a.pressCount), 32'd1);

    // Randomized phase: bouncy pins, random clears, occasional reset
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) raw[i] = ~raw[i];
      end
      cw    = ($urandom_range(0, 7) == 0);
      cm    = N'($urandom);
      cc    = ($urandom_range(0, 31) == 0);
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0; cw = 1'b0; cc = 1'b0;
    ticks(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/mmio_button_input.md
Name: mmio_button_input

Overview:
Input-direction companion to the MMIO output path that drives the LEDs and 7-segment display. It takes raw, asynchronous board inputs (push buttons), then synchronizes, debounces and edge-detects them. It presents them to the core's MMIO input port as a clean level, sticky press flags and a press counter. It sits between the board pins and the core's input port, replacing the direct pin-to-port connection.

Parameters:
NUM_INPUTS, 4, number of input channels.
DEBOUNCE_CYCLES, 16, consecutive stable synchronized cycles required to accept a change; legal values are 2 and above.
INVERT_INPUT, 0, 1 = raw pins are active-low and are inverted before the synchronizer.

Ports:
clock  input  1  system clock; all state is on its rising edge.
reset  input  1  synchronous, active-high reset.
rawInput  input  NUM_INPUTS  asynchronous pin levels.
clearWrite  input  1  single-cycle strobe that clears the press flags selected by clearMask.
clearMask  input  NUM_INPUTS  write-1-to-clear mask, qualified by clearWrite.
countClear  input  1  single-cycle strobe that zeroes pressCount.
debounced  output  NUM_INPUTS  debounced level per channel.
pressPending  output  NUM_INPUTS  sticky per-channel flag, set on a debounced 0->1 transition.
anyPending  output  1  OR-reduction of pressPending (registered-equivalent; no extra latency).
pressCount  output  8  saturating total count of accepted presses across all channels.

Behaviour:
- Reset (synchronous, active-high): both synchronizer stages, all debounce counters, debounced, pressPending, anyPending and pressCount go to 0. Reset overrides every other input on that edge.
- Input conditioning: the value sampled is rawInput XOR {NUM_INPUTS{INVERT_INPUT}}.
- Synchronizer: two flop stages, sync1 then sync2, per channel. No logic sits between the stages.
- Debounce, per channel i, evaluated each edge:
  - If sync2[i] == debounced[i]: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: debounced[i] <= sync2[i] and counter <= 0.
  - Else: counter <= counter+1.
  - Counter width is $clog2(DEBOUNCE_CYCLES).
- Latency: a clean step first sampled at edge n appears on debounced at edge n+DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 sampling edges.
- Glitch rejection: a sync2 excursion shorter than DEBOUNCE_CYCLES cycles leaves debounced unchanged and resets the counter when the excursion ends.
- Press detect: a rising edge is the edge on which debounced[i] goes 0->1.
  - pressPending[i] sets on that same edge.
  - A 1->0 release does not affect pressPending.
- Clear: when clearWrite=1, each pressPending[i] with clearMask[i]=1 clears at the next edge.
  - clearWrite=0 ignores clearMask.
  - Simultaneous set and clear on one channel: set wins (the flag stays 1).
- pressCount: on each edge it becomes min(255, pressCount + number of channels rising on that edge). It saturates at 255 and never wraps.
  - countClear=1 zeroes it. If a rise coincides with countClear, the result is the number of rises on that edge, not 0.
- Reset mid-operation: all state is lost and no event is generated by the reset itself.
  - If an input is held active through reset, debounced rises DEBOUNCE_CYCLES+2 sampling edges after reset deasserts, and one press is recorded.
- Channels are fully independent; simultaneous changes on several channels are each processed in the same cycle.

Test Plan:
1. DEBOUNCE_CYCLES=4, INVERT_INPUT=0. Step rawInput[0] 0->1 before edge 1 and hold -> debounced[0]=1 after edge 6, pressPending[0]=1, anyPending=1, pressCount=1. Nothing before edge 6.
2. DEBOUNCE_CYCLES=4. Pulse rawInput[1] high for 3 cycles, then low -> debounced, pressPending and pressCount all stay 0. Repeat with a 5-cycle pulse -> debounced[1] rises, then falls after 6 more cycles, and pressCount=1.
3. pressPending=4'b0011. Assert clearWrite with clearMask=4'b0001 -> pressPending=4'b0010. Assert clearWrite with clearMask=4'b0010 on the same edge that channel 1 rises again -> pressPending[1] stays 1 and pressCount increments.
4. Step all 4 channels together 64 times (each press followed by a full release) -> pressCount saturates at 255, and each further press leaves it at 255. Then countClear -> 0.
5. INVERT_INPUT=1, rawInput=4'b1111 idle -> all outputs 0. Drive rawInput[2]=0 -> debounced=4'b0100 after DEBOUNCE_CYCLES+2 edges.
6. Hold rawInput[3]=1, assert reset for 3 cycles mid-count with pressCount=7 -> all outputs 0 during reset. After release, debounced[3]=1 after 6 edges (DEBOUNCE_CYCLES=4) and pressCount=1.
